// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between an instruction-fetch port and a data port.
// Ports: clk, reset_n (async active-low)
//        i_readM/i_address -> i_data/i_ready           fetch port
//        d_readM/d_writeM/d_address/d_wdata -> d_rdata/d_ready   data port
//        mem_read/mem_write/mem_address/mem_wdata, mem_rdata     memory side
//        busy (access in progress), grant_d (current/last grant went to the data port)
module mem_port_arbiter #(
    parameter int LATENCY        = 2,
    parameter int DATA_BURST_MAX = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_readM,
    input  logic [15:0] i_address,
    output logic [15:0] i_data,
    output logic        i_ready,
    input  logic        d_readM,
    input  logic        d_writeM,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        grant_d
);
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [1:0] BURST_MAX = 2'(DATA_BURST_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  scnt_q, scnt_d;
    logic        grant_d_q, grant_d_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        d_req, pick_i, done;

    always_comb begin
        d_req         = d_readM | d_writeM;
        // a waiting fetch overtakes data only once the data port has used up its burst allowance
        pick_i        = i_readM && (!d_req || scnt_q == BURST_MAX);
        done          = state_q == BUSY && cnt_q == 4'd0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        scnt_d        = scnt_q;
        grant_d_d     = grant_d_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        if (state_q == IDLE) begin
            if (i_readM || d_req) begin
                state_d       = BUSY;
                cnt_d         = CNT_INIT;
                grant_d_d     = !pick_i;
                // read+write together on the data port is a write
                mem_write_d   = !pick_i && d_writeM;
                mem_read_d    = pick_i || !d_writeM;
                mem_address_d = pick_i ? i_address : d_address;
                mem_wdata_d   = pick_i ? 16'h0000 : d_wdata;
                scnt_d        = (pick_i || !i_readM) ? 2'd0 : (scnt_q == 2'd3 ? 2'd3 : scnt_q + 2'd1);
            end
        end else if (done) begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            scnt_q        <= 2'd0;
            grant_d_q     <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 16'h0000;
            mem_wdata_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            scnt_q        <= scnt_d;
            grant_d_q     <= grant_d_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign busy        = state_q == BUSY;
    assign grant_d     = grant_d_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_ready     = done && !grant_d_q;
    assign d_ready     = done && grant_d_q;
    assign i_data      = i_ready ? mem_rdata : 16'h0000;
    assign d_rdata     = (d_ready && mem_read_q) ? mem_rdata : 16'h0000;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: memory access cycles from grant to ready; legal range 1..15.
REQ-002 Parameter DATA_BURST_MAX, default 2: consecutive data grants allowed while an instruction request waits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_readM  input  1  instruction-fetch read request; held until i_ready seen.
REQ-006 i_address  input  16  fetch address.
REQ-007 i_data  output  16  fetch read data; valid only while i_ready=1.
REQ-008 i_ready  output  1  one-cycle fetch completion pulse.
REQ-009 d_readM  input  1  data read request; held until d_ready seen.
REQ-010 d_writeM  input  1  data write request; held until d_ready seen.
REQ-011 d_address  input  16  data address.
REQ-012 d_wdata  input  16  data write value.
REQ-013 d_rdata  output  16  data read value; valid only while d_ready=1.
REQ-014 d_ready  output  1  one-cycle data completion pulse.
REQ-015 mem_read, mem_write  output  1 each  memory strobes, held for the whole access.
REQ-016 mem_address  output  16  latched access address.
REQ-017 mem_wdata  output  16  latched write value.
REQ-018 mem_rdata  input  16  memory read data, valid in the final access cycle.
REQ-019 busy  output  1  access in progress; grant_d  output  1  current/last grant is data port.

Function
REQ-020 States: IDLE, BUSY; counter cnt 4 bits; starvation counter scnt 2 bits; owner flag grant_d.
REQ-021 IDLE, no request: remain IDLE; strobes low; ready outputs low.
REQ-022 IDLE, request sampled at posedge: enter BUSY, cnt=LATENCY-1, latch owner, address, write value, read/write kind.
REQ-023 Priority: data over instruction, except when scnt==DATA_BURST_MAX and i_readM=1, then instruction wins.
REQ-024 scnt increments on each data grant while i_readM=1, saturating; clears on any instruction grant or when i_readM=0 at a grant.
REQ-025 d_readM and d_writeM both 1: treated as write.
REQ-026 BUSY: mem_read/mem_write reflect latched kind; mem_address/mem_wdata constant; cnt decrements each cycle while nonzero.
REQ-027 BUSY with cnt==0: owner ready asserted combinationally that cycle; read data passed from mem_rdata to owner data output; next posedge returns to IDLE.
REQ-028 Latency: ready asserted exactly LATENCY cycles after the accepting edge; one access per LATENCY+1 cycles maximum.
REQ-029 Non-preemptive: requests arriving or changing during BUSY are ignored until IDLE.
REQ-030 Owner withdrawing its request mid-access: access completes, ready pulse still issued.
REQ-031 Non-owner ready and data outputs are 0 at all times.
REQ-032 Write completion: d_ready pulses; d_rdata=0.

Reset
REQ-033 reset_n=0 forces IDLE immediately, asynchronously: cnt=0, scnt=0, grant_d=0, all outputs 0.
REQ-034 Reset during BUSY aborts the access; no ready pulse is issued for it.

Verification
REQ-035 LATENCY=2, i_readM=1, i_address=0x0010, mem_rdata=0xBEEF -> mem_read high 2 cycles, i_ready pulse 2 cycles after grant, i_data=0xBEEF.
REQ-036 i_readM and d_readM asserted same cycle -> data granted first (grant_d=1); instruction granted in the following IDLE.
REQ-037 d_writeM held continuously with i_readM=1, DATA_BURST_MAX=2 -> grant order D,D,I,D,D,I.
REQ-038 d_writeM=1, d_address=0x0042, d_wdata=0x1234 -> mem_write high, mem_address=0x0042, mem_wdata=0x1234 stable for LATENCY cycles; d_ready one pulse.
REQ-039 reset_n low mid-BUSY -> outputs 0 same cycle, no ready pulse; after release, a new request is granted normally.
REQ-040 d_readM and d_writeM both 1 -> mem_write=1, mem_read=0.
